pc_unit: RTL and testbench

Program-counter stage of the single-cycle MIPS core, directly downstream of the branch AND gate. It consumes that gate's PCSrc result together with the jump controls, and registers the next instruction address every clock. It also supplies PC+4 to the register file (jal) and branch adder path, and tracks halt/fault status and a retired-instruction count for the testbench.

---
 rtl/mips_pkg.sv | 18 +
 rtl/next_pc_sel.sv | 41 ++++
 rtl/pc_unit.sv | 90 +++++++++
 tb/tb_pc_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and widths for the single-cycle MIPS core.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int JIDX_W = 26;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } pc_state_t;

  // Byte address of word index, used for jump and branch target formation.
  function automatic logic [WORD_W-1:0] word_to_byte(input logic [WORD_W-1:0] w);
    return w << 2;
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux (jr > jump > branch > sequential) with target legality check.
// Purely combinational; no state.
module next_pc_sel
  import mips_pkg::*;
#(
  parameter int IMEM_WORDS = 256
) (
  input  logic [WORD_W-1:0] pc_plus4,
  input  logic              pcsrc,
  input  logic              jump,
  input  logic              jr,
  input  logic [WORD_W-1:0] imm_ext,
  input  logic [JIDX_W-1:0] jtarget,
  input  logic [WORD_W-1:0] rs_value,
  output logic [WORD_W-1:0] next_pc,
  output logic              bad_target
);

  // One bit wider than a word so the limit itself cannot overflow.
  localparam logic [WORD_W:0] IMEM_LIMIT = (WORD_W+1)'(IMEM_WORDS) << 2;

  logic [WORD_W-1:0] branch_tgt;
  logic [WORD_W-1:0] jump_tgt;

  assign branch_tgt = pc_plus4 + word_to_byte(imm_ext);
  assign jump_tgt   = {pc_plus4[WORD_W-1:WORD_W-4], jtarget, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jr) begin
      next_pc = rs_value;
    end else if (jump) begin
      next_pc = jump_tgt;
    end else if (pcsrc) begin
      next_pc = branch_tgt;
    end
  end

  assign bad_target = (next_pc[1:0] != 2'b00) || ({1'b0, next_pc} >= IMEM_LIMIT);

endmodule

// File: rtl/pc_unit.sv
// Program counter, RUN/HALT/FAULT status and retired-instruction counter.
// Control inputs act one edge later; stall holds pc, count and state.
module pc_unit
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_ADDR = 32'h0000_0000,
  parameter int                IMEM_WORDS = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              pcsrc,
  input  logic              jump,
  input  logic              jr,
  input  logic [WORD_W-1:0] imm_ext,
  input  logic [JIDX_W-1:0] jtarget,
  input  logic [WORD_W-1:0] rs_value,
  input  logic              halt_req,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_plus4,
  output logic              halted,
  output logic              fault,
  output logic [WORD_W-1:0] retired
);

  pc_state_t         state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] retired_q, retired_d;
  logic [WORD_W-1:0] next_pc;
  logic              bad_target;

  assign pc_plus4 = pc_q + 32'd4;

  next_pc_sel #(
    .IMEM_WORDS (IMEM_WORDS)
  ) u_next_pc_sel (
    .pc_plus4   (pc_plus4),
    .pcsrc      (pcsrc),
    .jump       (jump),
    .jr         (jr),
    .imm_ext    (imm_ext),
    .jtarget    (jtarget),
    .rs_value   (rs_value),
    .next_pc    (next_pc),
    .bad_target (bad_target)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_ADDR;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  // On a fault the pc stays on the instruction that produced the bad target.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    case (state_q)
      RUN: begin
        if (stall) begin
          state_d = RUN;
        end else if (halt_req) begin
          state_d   = HALT;
          retired_d = retired_q + 32'd1;
        end else if (bad_target) begin
          state_d = FAULT;
        end else begin
          pc_d      = next_pc;
          retired_d = retired_q + 32'd1;
        end
      end
      HALT:    state_d = HALT;
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
  end

  assign pc      = pc_q;
  assign halted  = (state_q == HALT);
  assign fault   = (state_q == FAULT);
  assign retired = retired_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed and randomized checks of pc_unit against an in-bench reference model.
module tb_pc_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        pcsrc;
  logic        jump;
  logic        jr;
  logic [31:0] imm_ext;
  logic [25:0] jtarget;
  logic [31:0] rs_value;
  logic        halt_req;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        fault;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = running, 1 = halted, 2 = faulted.
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  int          m_st;
  bit          m_valid = 0;
  bit          preload = 0;

  always #5 clock = ~clock;

  pc_unit #(
    .RESET_ADDR (32'h0000_0000),
    .IMEM_WORDS (256)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .stall    (stall),
    .pcsrc    (pcsrc),
    .jump     (jump),
    .jr       (jr),
    .imm_ext  (imm_ext),
    .jtarget  (jtarget),
    .rs_value (rs_value),
    .halt_req (halt_req),
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .halted   (halted),
    .fault    (fault),
    .retired  (retired)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    logic [31:0] p4, np;
    if (preload) m_ret = 32'hFFFF_FFFF;
    if (reset) begin
      m_pc = 32'h0; m_ret = 32'h0; m_st = 0; m_valid = 1;
    end else if (m_st == 0 && !stall) begin
      p4 = m_pc + 32'd4;
      if (jr)         np = rs_value;
      else if (jump)  np = (p4 & 32'hF000_0000) | ({6'd0, jtarget} * 32'd4);
      else if (pcsrc) np = p4 + imm_ext * 32'd4;
      else            np = p4;
      if (halt_req) begin
        m_ret = m_ret + 32'd1; m_st = 1;
      end else if ((np % 4) != 0 || np >= 32'd1024) begin
        m_st = 2;
      end else begin
        m_pc = np; m_ret = m_ret + 32'd1;
      end
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      chk("m_pc", pc, m_pc);
      chk("m_pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("m_retired", retired, m_ret);
      chk("m_halted", {31'd0, halted}, {31'd0, m_st == 1});
      chk("m_fault", {31'd0, fault}, {31'd0, m_st == 2});
    end
  end

  task automatic idle();
    reset = 0; stall = 0; pcsrc = 0; jump = 0; jr = 0;
    imm_ext = 0; jtarget = 0; rs_value = 0; halt_req = 0;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    idle(); reset = 1; step(); reset = 0;
  endtask

  initial begin
    idle();
    do_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_flags", {30'd0, halted, fault}, 32'h0);
    step(); chk("seq_pc1", pc, 32'h4);
    step(); chk("seq_pc2", pc, 32'h8);
    step(); chk("seq_pc3", pc, 32'hC);
    chk("seq_retired", retired, 32'd3);
    chk("seq_flags", {30'd0, halted, fault}, 32'h0);
    step(); chk("seq_pc4", pc, 32'h10);

    pcsrc = 1; imm_ext = 32'hFFFF_FFFC; step();
    chk("branch_back", pc, 32'h04);
    jump = 1; jtarget = 26'h10; step();
    chk("jump_wins", pc, 32'h40);
    idle(); jr = 1; rs_value = 32'h20; step();
    chk("jr_20", pc, 32'h20);

    stall = 1; jr = 1; rs_value = 32'h80; step(); step();
    chk("stall_pc", pc, 32'h20);
    chk("stall_retired", retired, 32'd7);
    stall = 0; step();
    chk("jr_after_stall", pc, 32'h80);
    chk("retired_8", retired, 32'd8);

    rs_value = 32'h82; step();
    chk("misalign_fault", {31'd0, fault}, 32'd1);
    chk("misalign_pc", pc, 32'h80);
    idle(); pcsrc = 1; imm_ext = 32'h4; step();
    jump = 1; jtarget = 26'h4; step();
    chk("fault_frozen_pc", pc, 32'h80);
    chk("fault_frozen_ret", retired, 32'd8);
    do_reset();
    chk("fault_rst_pc", pc, 32'h0);
    chk("fault_rst_flag", {31'd0, fault}, 32'd0);
    jr = 1; rs_value = 32'h400; step();
    chk("range_fault", {31'd0, fault}, 32'd1);
    chk("range_pc", pc, 32'h0);
    jr = 1; rs_value = 32'h3FC; do_reset();

    repeat (5) step();
    chk("pre_halt_ret", retired, 32'd5);
    halt_req = 1; step();
    chk("halted", {31'd0, halted}, 32'd1);
    chk("halt_ret", retired, 32'd6);
    chk("halt_pc", pc, 32'h14);
    for (int i = 0; i < 10; i++) begin
      halt_req = $urandom_range(0, 1); jump = $urandom_range(0, 1);
      jtarget = 26'h8; step();
    end
    chk("halt_frozen_pc", pc, 32'h14);
    chk("halt_frozen_ret", retired, 32'd6);
    do_reset();
    chk("halt_rst_pc", pc, 32'h0);
    chk("halt_rst_ret", retired, 32'd0);
    chk("halt_rst_flag", {31'd0, halted}, 32'd0);

    #1 force dut.retired_q = 32'hFFFF_FFFF;
    preload = 1;
    #1 release dut.retired_q;
    @(posedge clock); #1 preload = 0;
    @(negedge clock);
    chk("wrap_ret", retired, 32'h0);
    chk("wrap_fault", {31'd0, fault}, 32'd0);
    chk("wrap_pc", pc, 32'h4);

    for (int i = 0; i < 3000; i++) begin
      idle();
      reset    = ($urandom_range(0, 99) < 3);
      stall    = ($urandom_range(0, 99) < 15);
      halt_req = ($urandom_range(0, 99) < 2);
      pcsrc    = $urandom_range(0, 1);
      jump     = ($urandom_range(0, 99) < 20);
      jr       = ($urandom_range(0, 99) < 15);
      imm_ext  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40))
                                             : -32'($urandom_range(0, 40));
      jtarget  = ($urandom_range(0, 9) == 0) ? 26'($urandom) : 26'($urandom_range(0, 255));
      rs_value = ($urandom_range(0, 9) == 0) ? $urandom : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
